wb_stage: RTL
=============

# wb_stage

Memory/write-back pipeline stage of the ARM core. Registers the MEM-stage result and selects ALU result or load data. Drives the register file's write port (`writeBackEn`, `destWB`, `resultWB`). Also keeps retired-instruction and retired-load counters for the test harness.

## Interface

Parameters:
- `DATA_W`, 32, data path width; must equal the register file word width.
- `ADDR_W`, 4, register index width (16 architectural registers).
- `CNT_W`, 32, width of each event counter.

Ports:
- `clk`  in  1  core clock; stage register updates on rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `freeze`  in  1  hold the stage register (memory stall).
- `flush`  in  1  load a bubble into the stage register.
- `cnt_clr`  in  1  synchronous clear of both counters.
- `mem_valid`  in  1  MEM stage holds a real instruction.
- `mem_wb_en`  in  1  instruction writes a register.
- `mem_r_en`  in  1  instruction is a load; select memory data.
- `mem_dest`  in  ADDR_W  destination register index.
- `mem_alu_res`  in  DATA_W  ALU result / effective address.
- `mem_data`  in  DATA_W  data returned by data memory.
- `writeBackEn`  out  1  register-file write enable.
- `destWB`  out  ADDR_W  register-file write index.
- `resultWB`  out  DATA_W  register-file write data.
- `wb_valid`  out  1  stage register holds a real instruction.
- `retired_cnt`  out  CNT_W  count of instructions captured into WB.
- `load_cnt`  out  CNT_W  count of loads captured into WB.

## Operation

- Stage register fields: `valid`, `wb_en`, `dest`, `result`.
- `result` is muxed before the register: `mem_r_en ? mem_data : mem_alu_res`. `resultWB` is a pure register output.
- Rising-edge priority, highest first:
  - `flush`: load a bubble (`valid`=0, `wb_en`=0, `dest`=0, `result`=0). Flush wins over `freeze`.
  - `freeze`: hold all fields.
  - Otherwise: capture the MEM inputs.
- `writeBackEn = valid & wb_en`. A bubble or a non-writing instruction never asserts it.
- `destWB = dest`, `wb_valid = valid`.
- Writes to index 15 pass through unmodified. PC handling is the fetch stage's concern.
- While frozen with `writeBackEn`=1, the register file rewrites the same value each cycle. This is idempotent and allowed.
- Counters advance only on a capture edge (no flush, no freeze, `mem_valid`=1):
  - `retired_cnt` += 1 on every capture edge.
  - `load_cnt` += 1 on a capture edge with `mem_r_en`=1.
- Counters wrap from 2^CNT_W−1 to 0 with no saturation.
- `cnt_clr` zeroes both counters on the next edge and wins over a simultaneous increment.

## Timing

- Reset: every output is 0, asserted immediately on `rst` rise, independent of `clk`.
  - Covers `writeBackEn`, `destWB`, `resultWB`, `wb_valid`, `retired_cnt`, `load_cnt`.
- Reset mid-stall or mid-flush: everything returns to 0. After release, the first capture edge behaves normally.
- Latency: MEM inputs at rising edge N appear on the WB outputs after edge N.
- The register file writes on the falling edge of cycle N. A decode read in cycle N+1 therefore sees the value with no forwarding.
- Counters update on the same edge as the capture. Their outputs are registered, with no combinational path from inputs.
- `freeze` and `flush` are sampled only at rising edges. A pulse between edges has no effect.

## Structure

- Shared package `arm_pkg`:
  - `DATA_W`, `ADDR_W` defaults.
  - Stage-register struct type (`valid`, `wb_en`, `dest`, `result`).
  - `WB_BUBBLE` constant (all zero).
- One sub-module, `wb_event_counter`, instantiated twice (retired, load):
  - Ports: `clk`, `rst`, `clr`, `inc`, `count`.
  - Parameter: `CNT_W`.
  - Async active-high reset; `clr` has priority over `inc`.
- Top level holds the stage register, the result mux and the output assigns.

## Test plan

1. Reset with all inputs active → all outputs 0. Release, then present ALU op (`mem_valid`=1, `mem_wb_en`=1, `mem_r_en`=0, dest 3, ALU 0x0000_00A5, data 0xDEAD_BEEF) → next cycle: `writeBackEn`=1, `destWB`=3, `resultWB`=0x0000_00A5, `retired_cnt`=1.
2. Load: dest 7, `mem_r_en`=1, data 0x1234_5678 → `resultWB`=0x1234_5678, `load_cnt`=1. Register 7 reads 0x1234_5678 in the following decode cycle.
3. Freeze 3 cycles with changing MEM inputs → outputs frozen and counters unchanged. On release, the next capture takes the current inputs.
4. `flush`=1 and `freeze`=1 together with a valid writing instruction → `wb_valid`=0, `writeBackEn`=0, `resultWB`=0, counters unchanged.
5. Preload counters to 0xFFFF_FFFF via repeated captures (or use `CNT_W`=4 with 15 captures), then capture one more → wraps to 0. Same edge with `cnt_clr`=1 → 0, no increment.
6. Assert `rst` asynchronously mid-cycle during a frozen valid write → outputs 0 before the next `clk` edge, with no register-file write afterward.

Source files
------------

// File: rtl/arm_pkg.sv
// Shared definitions for the ARM core pipeline: default widths and the
// write-back stage register layout.
package arm_pkg;

    localparam int ARM_DATA_W = 32;
    localparam int ARM_ADDR_W = 4;

    typedef struct packed {
        logic                  valid;
        logic                  wb_en;
        logic [ARM_ADDR_W-1:0] dest;
        logic [ARM_DATA_W-1:0] result;
    } wb_reg_t;

    localparam wb_reg_t WB_BUBBLE = '0;

    // Loads return memory data; everything else writes back the ALU result.
    function automatic logic [ARM_DATA_W-1:0] wb_select(
        input logic                  r_en,
        input logic [ARM_DATA_W-1:0] data,
        input logic [ARM_DATA_W-1:0] alu
    );
        return r_en ? data : alu;
    endfunction

endpackage

// File: rtl/wb_stage_if.sv
// MEM-to-WB bus: pipeline control, MEM-stage result and the register-file write port.
interface wb_stage_if
    import arm_pkg::*;
#(
    parameter int DATA_W = ARM_DATA_W,
    parameter int ADDR_W = ARM_ADDR_W
);
    logic              freeze;
    logic              flush;
    logic              mem_valid;
    logic              mem_wb_en;
    logic              mem_r_en;
    logic [ADDR_W-1:0] mem_dest;
    logic [DATA_W-1:0] mem_alu_res;
    logic [DATA_W-1:0] mem_data;

    logic              writeBackEn;
    logic [ADDR_W-1:0] destWB;
    logic [DATA_W-1:0] resultWB;
    logic              wb_valid;

    modport master (
        output freeze, flush, mem_valid, mem_wb_en, mem_r_en,
               mem_dest, mem_alu_res, mem_data,
        input  writeBackEn, destWB, resultWB, wb_valid
    );

    modport slave (
        input  freeze, flush, mem_valid, mem_wb_en, mem_r_en,
               mem_dest, mem_alu_res, mem_data,
        output writeBackEn, destWB, resultWB, wb_valid
    );
endinterface

// File: rtl/wb_event_counter.sv
// Free-running wrap-around event counter with synchronous clear.
module wb_event_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // Clear beats increment; the count wraps naturally at the top.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/wb_stage.sv
// Memory/write-back pipeline stage: registers the MEM result, drives the
// register-file write port and counts retired instructions and loads.
module wb_stage
    import arm_pkg::*;
#(
    parameter int DATA_W = ARM_DATA_W,
    parameter int ADDR_W = ARM_ADDR_W,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cnt_clr,
    wb_stage_if.slave        bus,
    output logic [CNT_W-1:0] retired_cnt,
    output logic [CNT_W-1:0] load_cnt
);

    wb_reg_t stage_q;
    wb_reg_t stage_d;
    logic    capture;
    logic    load_capture;

    always_comb begin
        stage_d        = WB_BUBBLE;
        stage_d.valid  = bus.mem_valid;
        stage_d.wb_en  = bus.mem_wb_en;
        stage_d.dest   = bus.mem_dest;
        stage_d.result = wb_select(bus.mem_r_en, bus.mem_data, bus.mem_alu_res);
    end

    // Flush outranks freeze so a squashed instruction never lingers in WB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q <= WB_BUBBLE;
        end else if (bus.flush) begin
            stage_q <= WB_BUBBLE;
        end else if (!bus.freeze) begin
            stage_q <= stage_d;
        end
    end

    assign capture      = !bus.flush && !bus.freeze && bus.mem_valid;
    assign load_capture = capture && bus.mem_r_en;

    wb_event_counter #(.CNT_W(CNT_W)) u_retired_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (capture),
        .count (retired_cnt)
    );

    wb_event_counter #(.CNT_W(CNT_W)) u_load_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (load_capture),
        .count (load_cnt)
    );

    assign bus.writeBackEn = stage_q.valid & stage_q.wb_en;
    assign bus.destWB      = stage_q.dest;
    assign bus.resultWB    = stage_q.result;
    assign bus.wb_valid    = stage_q.valid;

endmodule
